// File: rtl/paillier_pkg.sv
// Shared definitions for the Paillier encryption sequencer and the modexp bus.
// The key constants come from one public modulus N. The Montgomery radix is
// R = 2^W, which is the radix the shared modexp engine works in.
package paillier_pkg;

    localparam int N2_LENGTH_DEF  = 512;
    localparam int KEY_LENGTH_DEF = 256;

    // Engine word width: the N^2 length plus headroom for Montgomery reduction.
    function automatic int word_width(input int n2_length);
        return n2_length + 16;
    endfunction

    localparam int W_DEF = word_width(N2_LENGTH_DEF);

    // Task encodings on the shared modexp bus. This block issues only the first two.
    typedef enum logic [1:0] {
        TASK_EXP_N2    = 2'b00,
        TASK_MULT_N2   = 2'b01,
        TASK_MULT_N2P2 = 2'b10,
        TASK_MULT_N    = 2'b11
    } mx_task_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    localparam logic [KEY_LENGTH_DEF-1:0] KEY_N =
        256'h13611A1EC706880C740F5081ECE4FABD0866205F6DD4061577A9275E12695093;

    localparam logic [N2_LENGTH_DEF-1:0] KEY_N2 =
        N2_LENGTH_DEF'(KEY_N) * N2_LENGTH_DEF'(KEY_N);

    // These are elaboration-time products. The full width holds 2^(2W) without overflow.
    localparam int WIDE = 2 * W_DEF + 1;

    localparam logic [WIDE-1:0] R2_WIDE =
        (WIDE'(1) << (2 * W_DEF)) % WIDE'(KEY_N2);

    localparam logic [WIDE-1:0] G_MONT_WIDE =
        ((WIDE'(KEY_N) + WIDE'(1)) << W_DEF) % WIDE'(KEY_N2);

    // R^2 mod N^2 is used to move an operand into the Montgomery domain.
    localparam logic [W_DEF-1:0] R2_MOD_N2_DEF     = R2_WIDE[W_DEF-1:0];
    // (N+1)*R mod N^2 is the generator g, already in the Montgomery domain.
    localparam logic [W_DEF-1:0] N_PLUS_1_MONT_DEF = G_MONT_WIDE[W_DEF-1:0];

endpackage

// File: rtl/paillier_encrypt_seq.sv
// Paillier encryption sequencer: c = g^m * r^N mod N^2 with g = N+1.
// It drives five Montgomery-domain operations through the shared modexp engine
// and presents the ciphertext in the normal domain.
module paillier_encrypt_seq
    import paillier_pkg::*;
#(
    parameter int                      N2_LENGTH     = N2_LENGTH_DEF,
    parameter int                      KEY_LENGTH    = KEY_LENGTH_DEF,
    parameter logic [KEY_LENGTH-1:0]   N             = KEY_N,
    parameter logic [N2_LENGTH+15:0]   N_PLUS_1_MONT = N_PLUS_1_MONT_DEF,
    parameter logic [N2_LENGTH+15:0]   R2_MOD_N2     = R2_MOD_N2_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [KEY_LENGTH-1:0]   m,
    input  logic [N2_LENGTH+15:0]   r,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N2_LENGTH+15:0]   ciphertext,
    output logic                    mx_start,
    output logic [1:0]              mx_task,
    output logic [N2_LENGTH+15:0]   mx_base,
    output logic [N2_LENGTH+15:0]   mx_exponent,
    input  logic                    mx_done,
    input  logic [N2_LENGTH+15:0]   mx_power,
    output logic                    busy,
    output logic [2:0]              phase
);

    localparam int W = word_width(N2_LENGTH);
    localparam logic [2:0] LAST_PHASE = 3'd4;

    state_e                  state_q, state_d;
    logic [2:0]              phase_q, phase_d;
    logic [KEY_LENGTH-1:0]   m_q, m_d;
    logic [W-1:0]            rn_mont_q, rn_mont_d;
    logic [W-1:0]            gm_mont_q, gm_mont_d;
    logic [W-1:0]            prod_mont_q, prod_mont_d;
    logic [W-1:0]            ct_q, ct_d;
    logic                    mx_start_q, mx_start_d;
    logic [1:0]              mx_task_q, mx_task_d;
    logic [W-1:0]            mx_base_q, mx_base_d;
    logic [W-1:0]            mx_exp_q, mx_exp_d;
    logic                    load_ops;

    // Next-state, result capture and the operand mux for the phase being entered.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one unassigned and infers a latch.
        state_d     = state_q;
        phase_d     = phase_q;
        m_d         = m_q;
        rn_mont_d   = rn_mont_q;
        gm_mont_d   = gm_mont_q;
        prod_mont_d = prod_mont_q;
        ct_d        = ct_q;
        mx_start_d  = 1'b0;
        mx_task_d   = mx_task_q;
        mx_base_d   = mx_base_q;
        mx_exp_d    = mx_exp_q;
        load_ops    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    m_d       = m;
                    rn_mont_d = r;
                    phase_d   = 3'd0;
                    state_d   = ST_ISSUE;
                    load_ops  = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mx_done) begin
                    unique case (phase_q)
                        3'd0, 3'd1: rn_mont_d   = mx_power;
                        3'd2:       gm_mont_d   = mx_power;
                        3'd3:       prod_mont_d = mx_power;
                        default:    ct_d        = mx_power;
                    endcase
                    if (phase_q < LAST_PHASE) begin
                        phase_d  = phase_q + 3'd1;
                        state_d  = ST_ISSUE;
                        load_ops = 1'b1;
                    end else begin
                        state_d = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Operands are registered on entry to ISSUE. The mux uses the values
        // captured at the same edge, so each phase sees the previous result.
        if (load_ops) begin
            mx_start_d = 1'b1;
            unique case (phase_d)
                3'd0: begin
                    mx_task_d = TASK_MULT_N2;
                    mx_base_d = rn_mont_d;
                    mx_exp_d  = R2_MOD_N2;
                end
                3'd1: begin
                    mx_task_d = TASK_EXP_N2;
                    mx_base_d = rn_mont_d;
                    mx_exp_d  = {{(W-KEY_LENGTH){1'b0}}, N};
                end
                3'd2: begin
                    mx_task_d = TASK_EXP_N2;
                    mx_base_d = N_PLUS_1_MONT;
                    mx_exp_d  = {{(W-KEY_LENGTH){1'b0}}, m_d};
                end
                3'd3: begin
                    mx_task_d = TASK_MULT_N2;
                    mx_base_d = gm_mont_d;
                    mx_exp_d  = rn_mont_d;
                end
                default: begin
                    // A multiply by 1 removes the Montgomery factor.
                    mx_task_d = TASK_MULT_N2;
                    mx_base_d = prod_mont_d;
                    mx_exp_d  = W'(1);
                end
            endcase
        end
    end

    // State and datapath registers. Reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= 3'd0;
            m_q         <= '0;
            // NOTE: the scratch results are cleared on reset so a partial ciphertext from an aborted run can never reach the output.
            rn_mont_q   <= '0;
            gm_mont_q   <= '0;
            prod_mont_q <= '0;
            ct_q        <= '0;
            mx_start_q  <= 1'b0;
            mx_task_q   <= 2'b00;
            mx_base_q   <= '0;
            mx_exp_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop updating from the same pre-edge values.
            state_q     <= state_d;
            phase_q     <= phase_d;
            m_q         <= m_d;
            rn_mont_q   <= rn_mont_d;
            gm_mont_q   <= gm_mont_d;
            prod_mont_q <= prod_mont_d;
            ct_q        <= ct_d;
            mx_start_q  <= mx_start_d;
            mx_task_q   <= mx_task_d;
            mx_base_q   <= mx_base_d;
            mx_exp_q    <= mx_exp_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_OUT);
    assign busy        = (state_q != ST_IDLE);
    assign phase       = phase_q;
    assign ciphertext  = ct_q;
    assign mx_start    = mx_start_q;
    assign mx_task     = mx_task_q;
    assign mx_base     = mx_base_q;
    assign mx_exponent = mx_exp_q;

endmodule

// File: tb/tb_paillier_encrypt_seq.sv
// Directed bench for paillier_encrypt_seq. A behavioural modexp engine has a
// fixed 20-cycle latency and uses radix R = 1. With R = 1 the Montgomery
// constants become g = N+1 and R^2 = 1, so every expected ciphertext is plain
// modular arithmetic.
module tb_paillier_encrypt_seq;
    import paillier_pkg::*;

    localparam int W       = W_DEF;
    localparam int KL      = KEY_LENGTH_DEF;
    localparam int ENG_LAT = 20;
    localparam int EXP_LAT = 5 * (1 + ENG_LAT) + 1;

    localparam logic [W-1:0] N_W  = W'(KEY_N);
    localparam logic [W-1:0] N2_W = W'(KEY_N2);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [KL-1:0] m_i = '0;
    logic [W-1:0]  r_i = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  ciphertext;
    logic          mx_start;
    logic [1:0]    mx_task;
    logic [W-1:0]  mx_base;
    logic [W-1:0]  mx_exponent;
    logic          mx_done;
    logic [W-1:0]  mx_power;
    logic          busy;
    logic [2:0]    phase;

    logic          eng_done = 1'b0;
    logic [W-1:0]  eng_power = '0;
    logic          inj_done = 1'b0;
    logic [W-1:0]  inj_power = '0;

    assign mx_done  = eng_done | inj_done;
    assign mx_power = inj_done ? inj_power : eng_power;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int start_total = 0;
    logic [1:0]   task_log [0:63];
    logic [W-1:0] base_ph2, exp_ph2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    paillier_encrypt_seq #(
        .N2_LENGTH     (N2_LENGTH_DEF),
        .KEY_LENGTH    (KL),
        .N             (KEY_N),
        .N_PLUS_1_MONT (N_W + W'(1)),
        .R2_MOD_N2     (W'(1))
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .m           (m_i),
        .r           (r_i),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ciphertext  (ciphertext),
        .mx_start    (mx_start),
        .mx_task     (mx_task),
        .mx_base     (mx_base),
        .mx_exponent (mx_exponent),
        .mx_done     (mx_done),
        .mx_power    (mx_power),
        .busy        (busy),
        .phase       (phase)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mod_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = (2*W)'(a) * (2*W)'(b);
        p = p % (2*W)'(N2_W);
        return p[W-1:0];
    endfunction

    // Engine exponentiation scans the exponent from the top bit down.
    function automatic logic [W-1:0] eng_pow(input logic [W-1:0] b, input logic [W-1:0] e);
        logic [W-1:0] acc;
        acc = W'(1);
        for (int i = W - 1; i >= 0; i--) begin
            acc = mod_mul(acc, acc);
            if (e[i]) acc = mod_mul(acc, b);
        end
        return acc;
    endfunction

    // Reference exponentiation scans the exponent from bit 0 up.
    function automatic logic [W-1:0] ref_pow(input logic [W-1:0] b, input logic [W-1:0] e);
        logic [W-1:0] acc, sq, ee;
        acc = W'(1);
        sq  = b;
        ee  = e;
        while (ee != '0) begin
            if (ee[0]) acc = mod_mul(acc, sq);
            sq = mod_mul(sq, sq);
            ee = ee >> 1;
        end
        return acc;
    endfunction

    // Behavioural engine: samples start mid-cycle and raises done ENG_LAT cycles later.
    initial begin : engine
        logic [1:0]   t;
        logic [W-1:0] a, b, res;
        forever begin
            @(negedge clk);
            if (mx_start) begin
                t = mx_task;
                a = mx_base;
                b = mx_exponent;
                task_log[start_total & 63] = t;
                if (phase == 3'd2) begin
                    base_ph2 = a;
                    exp_ph2  = b;
                end
                start_total++;
                res = (t == TASK_EXP_N2) ? eng_pow(a, b) : mod_mul(a, b);
                repeat (ENG_LAT) @(posedge clk);
                #1 eng_done = 1'b1;
                eng_power = res;
                @(posedge clk);
                #1 eng_done = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [KL-1:0] mv, input logic [W-1:0] rv, input bit inject);
        @(negedge clk);
        check("accept_ready", W'(in_ready), W'(1));
        m_i = mv;
        r_i = rv;
        in_valid = 1'b1;
        accept_cyc = cyc;
        tick();
        in_valid = 1'b0;
        if (inject) begin
            // The DUT is in ISSUE now. This stray completion must be ignored.
            inj_power = {W{1'b1}};
            inj_done = 1'b1;
            tick();
            inj_done = 1'b0;
        end
    endtask

    task automatic wait_out(output int lat);
        int n;
        n = 0;
        while (!out_valid && n < 3000) begin
            tick();
            n++;
        end
        if (!out_valid) check("out_timeout", W'(out_valid), W'(1));
        lat = cyc - accept_cyc;
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hs_out_valid_low", W'(out_valid), W'(0));
        check("hs_in_ready_high", W'(in_ready), W'(1));
        check("hs_busy_low", W'(busy), W'(0));
    endtask

    initial begin : main
        int lat, base_cnt, n;
        logic [W-1:0] exp_ct, held_ct;
        logic [9:0] seq;

        #1;
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_mx_start", W'(mx_start), W'(0));
        check("rst_mx_task", W'(mx_task), W'(0));
        check("rst_mx_base", mx_base, '0);
        check("rst_mx_exponent", mx_exponent, '0);
        check("rst_ciphertext", ciphertext, '0);
        check("rst_busy", W'(busy), W'(0));
        check("rst_phase", W'(phase), W'(0));
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // m=0, r=1: ciphertext 1, five starts, tasks 01 00 00 01 01.
        base_cnt = start_total;
        start_op(KL'(0), W'(1), 1'b0);
        check("t1_busy", W'(busy), W'(1));
        wait_out(lat);
        check("t1_ct", ciphertext, W'(1));
        check("t1_starts", W'(start_total - base_cnt), W'(5));
        seq = {task_log[base_cnt & 63], task_log[(base_cnt + 1) & 63], task_log[(base_cnt + 2) & 63],
               task_log[(base_cnt + 3) & 63], task_log[(base_cnt + 4) & 63]};
        check("t1_task_seq", W'(seq), W'(10'b01_00_00_01_01));
        handshake();

        // m=1, r=1: ciphertext N+1. out_valid is held, and a new request is refused while OUT.
        start_op(KL'(1), W'(1), 1'b0);
        wait_out(lat);
        check("t2_ct", ciphertext, N_W + W'(1));
        check("t2_ph2_base", base_ph2, N_W + W'(1));
        check("t2_ph2_exp", exp_ph2, W'(1));
        held_ct = ciphertext;
        @(negedge clk);
        in_valid = 1'b1;
        m_i = KL'(9);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t2_hold_valid", W'(out_valid), W'(1));
            check("t2_hold_ct", ciphertext, N_W + W'(1));
            check("t2_hold_in_ready", W'(in_ready), W'(0));
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("t2_still_stable", ciphertext, held_ct);
        handshake();
        check("t2_phase_idle", W'(phase), W'(4));

        // m=5, r=3 with the fixed-latency engine: latency and the full formula.
        start_op(KL'(5), W'(3), 1'b0);
        wait_out(lat);
        check("t3_latency", W'(lat), W'(EXP_LAT));
        exp_ct = mod_mul(W'(1) + mod_mul(W'(5), N_W), ref_pow(W'(3), N_W));
        check("t3_ct", ciphertext, exp_ct);
        handshake();

        // A stray completion in IDLE changes nothing.
        @(negedge clk);
        inj_power = {W{1'b1}};
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        tick();
        check("idle_inj_ct", ciphertext, exp_ct);
        check("idle_inj_ready", W'(in_ready), W'(1));
        check("idle_inj_busy", W'(busy), W'(0));

        // Reset during WAIT of phase 2. The engine's late done must be ignored.
        start_op(KL'(7), W'(2), 1'b0);
        n = 0;
        while (!(mx_start && phase == 3'd2) && n < 1000) begin
            tick();
            n++;
        end
        check("rst_reach_ph2", W'(mx_start && phase == 3'd2), W'(1));
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", W'(in_ready), W'(1));
        check("abort_out_valid", W'(out_valid), W'(0));
        check("abort_busy", W'(busy), W'(0));
        check("abort_phase", W'(phase), W'(0));
        check("abort_mx_base", mx_base, '0);
        check("abort_ct", ciphertext, '0);
        @(negedge clk) rst_n = 1'b1;
        base_cnt = start_total;
        repeat (30) tick();
        check("post_rst_in_ready", W'(in_ready), W'(1));
        check("post_rst_phase", W'(phase), W'(0));
        check("post_rst_out_valid", W'(out_valid), W'(0));
        check("post_rst_ct", ciphertext, '0);
        check("post_rst_no_start", W'(start_total - base_cnt), W'(0));

        // The next request completes correctly, with a stray done injected during ISSUE.
        start_op(KL'(2), W'(1), 1'b1);
        wait_out(lat);
        check("t5_latency", W'(lat), W'(EXP_LAT));
        check("t5_ct", ciphertext, W'(1) + mod_mul(W'(2), N_W));
        handshake();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/paillier_encrypt_seq.md
Name: paillier_encrypt_seq

Overview:
- Upstream sequencer for the modexp_triple_M engine; computes Paillier ciphertext c = g^m · r^N mod N², with g = N+1.
- Issues five engine operations in Montgomery domain:
  1. convert r into Montgomery form
  2. raise r to N
  3. raise g to m
  4. multiply the two results
  5. convert back out of Montgomery form
- Sits between the host operand interface and the single shared modexp instance.

Parameters:
- N2_LENGTH, 512, bit length of N²; engine word width W = N2_LENGTH+16.
- KEY_LENGTH, 256, bit length of N and of plaintext m.
- N, 256'h13611A1EC706880C740F5081ECE4FABD0866205F6DD4061577A9275E12695093, public modulus used as exponent in phase 1.
- N_PLUS_1_MONT, 508'hA613…BDF (team key constant), Montgomery form of g = N+1 mod N².
- R2_MOD_N2, 508'hBDD0…4476 (team key constant), R² mod N², for conversion into Montgomery form.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  plaintext/randomness request valid
- in_ready  out  1  sequencer idle, accepts request
- m  in  KEY_LENGTH  plaintext, m < N
- r  in  W  random value, 0 < r < N
- out_valid  out  1  ciphertext valid
- out_ready  in  1  consumer accepts ciphertext
- ciphertext  out  W  c mod N², normal (non-Montgomery) domain
- mx_start  out  1  one-cycle start pulse to modexp
- mx_task  out  2  task: 00 exp mod N², 01 mult mod N², 10 mult mod N²+2, 11 mult mod N
- mx_base  out  W  modexp base operand
- mx_exponent  out  W  modexp exponent / second multiplicand
- mx_done  in  1  modexp done pulse
- mx_power  in  W  modexp result, valid in the cycle mx_done=1
- busy  out  1  high from accept until out_valid handshake
- phase  out  3  current phase index, debug

Behaviour:
- Reset (async on rst_n low, all registers cleared):
  - state=IDLE, phase=0, in_ready=1, out_valid=0, mx_start=0, mx_task=0, mx_base=0, mx_exponent=0, ciphertext=0, busy=0.
- Clear scratch registers rn_mont, gm_mont and prod_mont (W bits each) on reset.
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch m, and zero-extended r into rn_mont; phase←0; go to ISSUE.
- ISSUE (exactly one cycle): mx_start=1; mx_task/base/exponent driven per phase from registers; go to WAIT.
  - Phase 0: task 01, base=r, exp=R2_MOD_N2 → rn_mont ← r·R mod N².
  - Phase 1: task 00, base=rn_mont, exp=N zero-extended → rn_mont ← (r^N)·R.
  - Phase 2: task 00, base=N_PLUS_1_MONT, exp=m zero-extended → gm_mont.
  - Phase 3: task 01, base=gm_mont, exp=rn_mont → prod_mont.
  - Phase 4: task 01, base=prod_mont, exp=1 → ciphertext register.
- Operand hold: mx_task, mx_base and mx_exponent stay registered and stable from ISSUE through WAIT. The engine samples them only on start, but they are held regardless.
- WAIT:
  - On mx_done: capture mx_power into the phase destination in the same cycle.
  - If phase<4: phase+1, go to ISSUE. Otherwise go to OUT.
- mx_done outside WAIT is ignored. This covers stray completions from an engine that was not reset.
- OUT:
  - out_valid=1, ciphertext held stable.
  - On out_ready: out_valid←0, busy←0, go to IDLE. in_ready rises the following cycle.
- in_ready=0 in ISSUE/WAIT/OUT; requests are not queued.
- Latency from accept to out_valid: 5 ISSUE cycles + sum of the five engine latencies + 1.
- Operand widths: exponent for phase 2 uses bits [KEY_LENGTH-1:0]; upper bits are zero.
- mx_task value 10/11 is never issued by this block; the encoding is carried only for the shared bus.
- Reset mid-operation: immediate abort to IDLE, outputs to reset values. No partial ciphertext is ever presented.

Decomposition:
- Shared package (paillier_pkg):
  - modexp task encodings TASK_EXP_N2=2'b00, TASK_MULT_N2=2'b01, TASK_MULT_N2P2=2'b10, TASK_MULT_N=2'b11
  - state encodings
  - W derivation
  - key constants
- Single module; no sub-module. The phase→operand mux is inline combinational logic feeding registered mx_* outputs.

Test Plan:
- m=0, r=1, with the real modexp_triple_M -> ciphertext = 1; exactly 5 mx_start pulses; task sequence 01,00,00,01,01.
- m=1, r=1 -> ciphertext = N+1 (0x13611A1E…5094); out_valid held until out_ready.
- Behavioural engine model with fixed 20-cycle latency, m=5, r=3 -> out_valid exactly 5·(1+20)+1 cycles after accept; ciphertext equals software model (N+1)^5·3^N mod N².
- Hold out_ready=0 for 10 cycles in OUT -> out_valid and ciphertext stable; in_ready=0; a second in_valid is not accepted until after the handshake.
- Assert rst_n low during WAIT of phase 2, then release; the engine model then emits mx_done -> outputs at reset values, state IDLE, done ignored, next request completes correctly.
- Inject mx_done pulse while in IDLE and during ISSUE -> no state or register change.
